// File: rtl/rps_match.sv
// rtl/rps_match.sv - best-of-N rock-paper-scissors match engine with LFSR bot opponent
// Define RPS_BOT_ADAPTIVE_EN to make the bot counter player 1's previous move.
module rps_match #(
  parameter int         ROUNDS_TO_WIN = 3,
  parameter int         MAX_ROUNDS    = 9,
  parameter int         CNT_W         = 4,
  parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             start,
  input  logic             play_with_bot,
  input  logic [2:0]       player1_input,
  input  logic [2:0]       player2_input,
  input  logic             input_valid,
  output logic             ready,
  output logic [2:0]       player1_choice,
  output logic [2:0]       player2_choice,
  output logic [2:0]       winner_output,
  output logic             round_done,
  output logic             input_err,
  output logic [CNT_W-1:0] p1_score,
  output logic [CNT_W-1:0] p2_score,
  output logic [CNT_W-1:0] round_count,
  output logic             match_over,
  output logic [1:0]       match_winner
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_JUDGE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0]       SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [CNT_W-1:0] RTW      = CNT_W'(ROUNDS_TO_WIN);
  localparam logic [CNT_W-1:0] MAXR     = CNT_W'(MAX_ROUNDS);

  localparam logic [2:0] ROCK     = 3'b001;
  localparam logic [2:0] PAPER    = 3'b010;
  localparam logic [2:0] SCISSORS = 3'b100;

  logic [1:0]       state_q, state_d;
  logic             bot_mode_q, bot_mode_d;
  logic [2:0]       p1_choice_q, p1_choice_d;
  logic [2:0]       p2_choice_q, p2_choice_d;
  logic [2:0]       winner_q, winner_d;
  logic             round_done_q, round_done_d;
  logic             input_err_q, input_err_d;
  logic [CNT_W-1:0] p1_score_q, p1_score_d;
  logic [CNT_W-1:0] p2_score_q, p2_score_d;
  logic [CNT_W-1:0] round_cnt_q, round_cnt_d;
  logic             match_over_q, match_over_d;
  logic [1:0]       match_winner_q, match_winner_d;
  logic [7:0]       lfsr_q, lfsr_d;

  logic [2:0]       lfsr_move, bot_move;
  logic             p1_wins, is_draw;
  logic [CNT_W-1:0] p1_next, p2_next, round_next;

  function automatic logic is_onehot(input logic [2:0] v);
    return (v == ROCK) || (v == PAPER) || (v == SCISSORS);
  endfunction

  function automatic logic [2:0] map2(input logic [1:0] b);
    case (b)
      2'b00:   return ROCK;
      2'b01:   return PAPER;
      default: return SCISSORS;
    endcase
  endfunction

  // Low pair 11 falls back to the next pair; both 11 yields paper.
  always_comb begin
    if (lfsr_q[1:0] != 2'b11)      lfsr_move = map2(lfsr_q[1:0]);
    else if (lfsr_q[3:2] != 2'b11) lfsr_move = map2(lfsr_q[3:2]);
    else                           lfsr_move = PAPER;
  end

`ifdef RPS_BOT_ADAPTIVE_EN
  function automatic logic [2:0] beater(input logic [2:0] m);
    case (m)
      ROCK:    return PAPER;
      PAPER:   return SCISSORS;
      default: return ROCK;
    endcase
  endfunction

  assign bot_move = (round_cnt_q != '0) ? beater(p1_choice_q) : lfsr_move;
`else
  assign bot_move = lfsr_move;
`endif

  assign is_draw = (p1_choice_q == p2_choice_q);
  assign p1_wins = ((p1_choice_q == ROCK)     && (p2_choice_q == SCISSORS)) ||
                   ((p1_choice_q == SCISSORS) && (p2_choice_q == PAPER))    ||
                   ((p1_choice_q == PAPER)    && (p2_choice_q == ROCK));

  assign p1_next    = p1_score_q + CNT_W'(p1_wins);
  assign p2_next    = p2_score_q + CNT_W'(!p1_wins && !is_draw);
  assign round_next = round_cnt_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    bot_mode_d     = bot_mode_q;
    p1_choice_d    = p1_choice_q;
    p2_choice_d    = p2_choice_q;
    winner_d       = winner_q;
    round_done_d   = 1'b0;
    input_err_d    = 1'b0;
    p1_score_d     = p1_score_q;
    p2_score_d     = p2_score_q;
    round_cnt_d    = round_cnt_q;
    match_over_d   = match_over_q;
    match_winner_d = match_winner_q;
    lfsr_d         = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d        = S_WAIT;
          bot_mode_d     = play_with_bot;
          winner_d       = 3'b000;
          p1_score_d     = '0;
          p2_score_d     = '0;
          round_cnt_d    = '0;
          match_over_d   = 1'b0;
          match_winner_d = 2'b00;
        end
      end
      S_WAIT: begin
        if (input_valid) begin
          if (is_onehot(player1_input) && (bot_mode_q || is_onehot(player2_input))) begin
            p1_choice_d = player1_input;
            p2_choice_d = bot_mode_q ? bot_move : player2_input;
            state_d     = S_JUDGE;
          end else begin
            input_err_d = 1'b1;
          end
        end
      end
      S_JUDGE: begin
        winner_d     = is_draw ? 3'b100 : (p1_wins ? 3'b001 : 3'b010);
        p1_score_d   = p1_next;
        p2_score_d   = p2_next;
        round_cnt_d  = round_next;
        round_done_d = 1'b1;
        state_d      = S_WAIT;
        if (p1_next == RTW) begin
          state_d        = S_DONE;
          match_over_d   = 1'b1;
          match_winner_d = 2'b01;
        end else if (p2_next == RTW) begin
          state_d        = S_DONE;
          match_over_d   = 1'b1;
          match_winner_d = 2'b10;
        end else if (round_next == MAXR) begin
          state_d        = S_DONE;
          match_over_d   = 1'b1;
          match_winner_d = (p1_next > p2_next) ? 2'b01 :
                           (p2_next > p1_next) ? 2'b10 : 2'b11;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q        <= S_IDLE;
      bot_mode_q     <= 1'b0;
      p1_choice_q    <= 3'b000;
      p2_choice_q    <= 3'b000;
      winner_q       <= 3'b000;
      round_done_q   <= 1'b0;
      input_err_q    <= 1'b0;
      p1_score_q     <= '0;
      p2_score_q     <= '0;
      round_cnt_q    <= '0;
      match_over_q   <= 1'b0;
      match_winner_q <= 2'b00;
      lfsr_q         <= SEED_EFF;
    end else begin
      state_q        <= state_d;
      bot_mode_q     <= bot_mode_d;
      p1_choice_q    <= p1_choice_d;
      p2_choice_q    <= p2_choice_d;
      winner_q       <= winner_d;
      round_done_q   <= round_done_d;
      input_err_q    <= input_err_d;
      p1_score_q     <= p1_score_d;
      p2_score_q     <= p2_score_d;
      round_cnt_q    <= round_cnt_d;
      match_over_q   <= match_over_d;
      match_winner_q <= match_winner_d;
      lfsr_q         <= lfsr_d;
    end
  end

  assign ready          = (state_q == S_WAIT);
  assign player1_choice = p1_choice_q;
  assign player2_choice = p2_choice_q;
  assign winner_output  = winner_q;
  assign round_done     = round_done_q;
  assign input_err      = input_err_q;
  assign p1_score       = p1_score_q;
  assign p2_score       = p2_score_q;
  assign round_count    = round_cnt_q;
  assign match_over     = match_over_q;
  assign match_winner   = match_winner_q;

endmodule

// File: tb/tb_rps_match.sv
// tb/tb_rps_match.sv - directed self-checking bench for rps_match (default and MAX_ROUNDS=3 instances)
module tb_rps_match;

  logic       clk = 1'b0;
  logic       rst, start, bot;
  logic [2:0] p1, p2;
  logic       valid;

  logic       ready, rdone, ierr, mover;
  logic [2:0] c1, c2, win;
  logic [3:0] s1, s2, rcnt;
  logic [1:0] mwin;

  logic       c_ready, c_rdone, c_ierr, c_mover;
  logic [2:0] c_c1, c_c2, c_win;
  logic [3:0] c_s1, c_s2, c_rcnt;
  logic [1:0] c_mwin;

  logic [7:0] lfsr_m;
  int         nvec = 0;
  int         nerr = 0;

  always #5 clk = ~clk;

  rps_match dut (
    .Clk(clk), .Rst(rst), .start(start), .play_with_bot(bot),
    .player1_input(p1), .player2_input(p2), .input_valid(valid),
    .ready(ready), .player1_choice(c1), .player2_choice(c2),
    .winner_output(win), .round_done(rdone), .input_err(ierr),
    .p1_score(s1), .p2_score(s2), .round_count(rcnt),
    .match_over(mover), .match_winner(mwin)
  );

  rps_match #(.MAX_ROUNDS(3)) dut_cap (
    .Clk(clk), .Rst(rst), .start(start), .play_with_bot(bot),
    .player1_input(p1), .player2_input(p2), .input_valid(valid),
    .ready(c_ready), .player1_choice(c_c1), .player2_choice(c_c2),
    .winner_output(c_win), .round_done(c_rdone), .input_err(c_ierr),
    .p1_score(c_s1), .p2_score(c_s2), .round_count(c_rcnt),
    .match_over(c_mover), .match_winner(c_mwin)
  );

  // Golden bot LFSR, tracking the DUT from reset.
  always @(posedge clk) begin
    if (rst) lfsr_m <= 8'hA5;
    else     lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  function automatic logic [2:0] map2(input logic [1:0] b);
    case (b)
      2'b00:   return 3'b001;
      2'b01:   return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] bot_pick(input logic [7:0] l);
    if (l[1:0] != 2'b11) return map2(l[1:0]);
    if (l[3:2] != 2'b11) return map2(l[3:2]);
    return 3'b010;
  endfunction

  function automatic logic [2:0] beat(input logic [2:0] m);
    case (m)
      3'b001:  return 3'b010;
      3'b010:  return 3'b100;
      default: return 3'b001;
    endcase
  endfunction

  function automatic logic [2:0] judge(input logic [2:0] a, input logic [2:0] b);
    if (a == b) return 3'b100;
    if ((a == 3'b001 && b == 3'b100) || (a == 3'b010 && b == 3'b001) ||
        (a == 3'b100 && b == 3'b010)) return 3'b001;
    return 3'b010;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer a move pair at cycle N with valid held through JUDGE; returns in N+2.
  task automatic play(input logic [2:0] a, input logic [2:0] b);
    p1 = a; p2 = b; valid = 1'b1;
    @(negedge clk);
    chk("ready_in_judge", {7'd0, ready}, 8'd0);
    chk("rdone_in_judge", {7'd0, rdone}, 8'd0);
    @(negedge clk);
    valid = 1'b0;
  endtask

  initial begin
    logic [2:0] exp_bot, mv, prev_p1;
    int         rim;
    logic [2:0] rot [3];
    rot[0] = 3'b001; rot[1] = 3'b010; rot[2] = 3'b100;

    rst = 1'b1; start = 1'b0; bot = 1'b0; p1 = 3'b000; p2 = 3'b000; valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready",  {7'd0, ready}, 8'd0);
    chk("rst_c1",     {5'd0, c1}, 8'd0);
    chk("rst_c2",     {5'd0, c2}, 8'd0);
    chk("rst_win",    {5'd0, win}, 8'd0);
    chk("rst_rdone",  {7'd0, rdone}, 8'd0);
    chk("rst_ierr",   {7'd0, ierr}, 8'd0);
    chk("rst_rcnt",   {4'd0, rcnt}, 8'd0);
    chk("rst_s1",     {4'd0, s1}, 8'd0);
    chk("rst_mover",  {7'd0, mover}, 8'd0);
    chk("rst_mwin",   {6'd0, mwin}, 8'd0);
    rst = 1'b0;

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ready", {7'd0, ready}, 8'd1);

    // Non-one-hot player 1 move is rejected.
    p1 = 3'b011; p2 = 3'b001; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    chk("ierr_pulse", {7'd0, ierr}, 8'd1);
    chk("ierr_ready", {7'd0, ready}, 8'd1);
    chk("ierr_rcnt",  {4'd0, rcnt}, 8'd0);
    @(negedge clk);
    chk("ierr_clear", {7'd0, ierr}, 8'd0);

    play(3'b001, 3'b100);
    chk("r1_rdone", {7'd0, rdone}, 8'd1);
    chk("r1_win",   {5'd0, win}, 8'd1);
    chk("r1_s1",    {4'd0, s1}, 8'd1);
    chk("r1_rcnt",  {4'd0, rcnt}, 8'd1);
    @(negedge clk);
    chk("r1_rdone_low", {7'd0, rdone}, 8'd0);
    chk("r1_no_double", {4'd0, rcnt}, 8'd1);
    chk("r1_ready",     {7'd0, ready}, 8'd1);

    play(3'b010, 3'b001);
    chk("r2_win", {5'd0, win}, 8'd1);
    chk("r2_s1",  {4'd0, s1}, 8'd2);
    play(3'b100, 3'b010);
    chk("r3_win",   {5'd0, win}, 8'd1);
    chk("r3_s1",    {4'd0, s1}, 8'd3);
    chk("r3_rdone", {7'd0, rdone}, 8'd1);
    chk("r3_mover", {7'd0, mover}, 8'd1);
    chk("r3_mwin",  {6'd0, mwin}, 8'd1);
    chk("r3_ready", {7'd0, ready}, 8'd0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_mover", {7'd0, mover}, 8'd0);
    chk("restart_s1",    {4'd0, s1}, 8'd0);
    play(3'b001, 3'b010);
    chk("p2win_win", {5'd0, win}, 8'd2);
    chk("p2win_s2",  {4'd0, s2}, 8'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ign_s2",   {4'd0, s2}, 8'd1);
    chk("start_ign_rcnt", {4'd0, rcnt}, 8'd1);
    chk("start_ign_rdy",  {7'd0, ready}, 8'd1);

    // Reset while in JUDGE.
    p1 = 3'b001; p2 = 3'b001; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rj_ready", {7'd0, ready}, 8'd0);
    chk("rj_rdone", {7'd0, rdone}, 8'd0);
    chk("rj_win",   {5'd0, win}, 8'd0);
    chk("rj_s2",    {4'd0, s2}, 8'd0);
    chk("rj_rcnt",  {4'd0, rcnt}, 8'd0);
    chk("rj_c1",    {5'd0, c1}, 8'd0);
    rst = 1'b0;

    // Draw cap on the MAX_ROUNDS=3 instance.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) play(3'b010, 3'b010);
    chk("cap_win",    {5'd0, c_win}, 8'h04);
    chk("cap_rcnt",   {4'd0, c_rcnt}, 8'd3);
    chk("cap_mwin",   {6'd0, c_mwin}, 8'h03);
    chk("cap_mover",  {7'd0, c_mover}, 8'd1);
    chk("cap_rdone",  {7'd0, c_rdone}, 8'd1);
    chk("def_mover",  {7'd0, mover}, 8'd0);
    chk("def_rcnt",   {4'd0, rcnt}, 8'd3);

    // Bot mode against the golden LFSR.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bot = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bot = 1'b0;
    rim = 0; prev_p1 = 3'b000;
    for (int k = 0; k < 10; k++) begin
      if (mover) begin
        bot = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; bot = 1'b0;
        rim = 0;
      end
      mv = rot[k % 3];
`ifdef RPS_BOT_ADAPTIVE_EN
      exp_bot = (rim != 0) ? beat(prev_p1) : bot_pick(lfsr_m);
`else
      exp_bot = bot_pick(lfsr_m);
`endif
      play(mv, 3'b111);
      chk($sformatf("bot_move_%0d", k), {5'd0, c2}, {5'd0, exp_bot});
      chk($sformatf("bot_win_%0d", k), {5'd0, win}, {5'd0, judge(mv, exp_bot)});
      prev_p1 = mv;
      rim++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rps_match.md
# rps_match

Best-of-N Rock-Paper-Scissors match engine, the parametrised successor of the single-round Rock_Paper_Scissors block. It accepts one-hot moves through a valid/ready handshake, supplies an internal LFSR bot opponent, judges each round, keeps per-player scores and a round count, and declares a match winner. It sits between the player input debouncers and the score display driver.

## Interface
- ROUNDS_TO_WIN, default 3: round wins needed to take the match (1..2^CNT_W-1).
- MAX_ROUNDS, default 9: hard cap on judged rounds, draws included (>= ROUNDS_TO_WIN).
- CNT_W, default 4: width of the score and round counters; must hold MAX_ROUNDS.
- LFSR_SEED, default 8'hA5: bot LFSR reset value; 8'h00 is replaced by 8'h01.
- Clk  in  1  single clock; all logic is rising-edge.
- Rst  in  1  synchronous, active-high reset.
- start  in  1  begin a new match; honoured only in IDLE or DONE.
- play_with_bot  in  1  1 = player 2 is the internal bot; sampled on start only.
- player1_input  in  3  one-hot move: 001 rock, 010 paper, 100 scissors.
- player2_input  in  3  same encoding; ignored in bot mode.
- input_valid  in  1  move pair offered.
- ready  out  1  high only in WAIT_MOVE.
- player1_choice  out  3  latched player 1 move.
- player2_choice  out  3  latched player 2 or bot move.
- winner_output  out  3  last round result: 001 P1, 010 P2, 100 draw, 000 none.
- round_done  out  1  one-cycle pulse per judged round.
- input_err  out  1  one-cycle pulse on a rejected (non-one-hot) offer.
- p1_score, p2_score, round_count  out  CNT_W  match counters.
- match_over  out  1  high in DONE.
- match_winner  out  2  01 P1, 10 P2, 11 tie, 00 none.

## Operation
- States: IDLE, WAIT_MOVE, JUDGE, DONE. Rst forces IDLE from any state, including mid-round.
- IDLE/DONE + start: clear scores, round_count, winner_output, match_winner, match_over; latch play_with_bot; go to WAIT_MOVE. LFSR is not reseeded by start.
- WAIT_MOVE, input_valid=1: if player1_input, and player2_input when not in bot mode, are one-hot, latch both choices (bot move taken from the current LFSR) and go to JUDGE; otherwise pulse input_err, latch nothing, stay in WAIT_MOVE.
- JUDGE: rock beats scissors, scissors beat paper, paper beats rock, equal moves draw. Update winner_output, increment the winner's score, increment round_count, pulse round_done.
- After JUDGE: if a score equals ROUNDS_TO_WIN, go to DONE with that player as winner. Else if round_count equals MAX_ROUNDS, go to DONE with the higher score winning, and equal scores giving 11. Else return to WAIT_MOVE.
- start is ignored in WAIT_MOVE and JUDGE. input_valid is ignored outside WAIT_MOVE.
- Bot LFSR: 8 bits, shifts left every cycle including IDLE. Feedback is l[7]^l[5]^l[4]^l[3].
- Bot move mapping: l[1:0] 00 rock, 01 paper, 10 scissors. For 11, use l[3:2] with the same mapping. If that is also 11, the move is paper.

## Timing
- Reset values: ready 0, both choices 000, winner_output 000, round_done 0, input_err 0, all counters 0, match_over 0, match_winner 00, LFSR at LFSR_SEED.
- Accept edge at cycle N (input_valid & ready). State is JUDGE in N+1. round_done, winner_output and counters update at the N+1 edge and are visible in N+2. ready is high again in N+2 unless the match ended.
- input_err is visible the cycle after the rejected offer.
- match_over and match_winner are visible in the same cycle as the final round_done.
- start to ready: 1 cycle.

## Configuration
- RPS_BOT_ADAPTIVE_EN defined: from the second round on, the bot plays the move that beats player 1's previous latched move. Round 1 uses the LFSR.
- RPS_BOT_ADAPTIVE_EN undefined: every bot move comes from the LFSR. No adaptive logic is synthesised.

## Test plan
- Two-player 001 vs 100, 010 vs 001, 100 vs 010 with defaults -> winner_output 001 each round, p1_score 3, match_over=1 and match_winner=01 alongside the third round_done.
- Draw cap: set MAX_ROUNDS=3 and play three 010/010 rounds -> winner_output 100, round_count 3, match_winner 11.
- Invalid move: player1_input=011 with input_valid -> input_err pulse, ready stays 1, counters unchanged.
- Handshake latency: accept at cycle N -> round_done visible only in N+2, ready low in N+1. input_valid held through JUDGE must not double-count.
- Bot mode, seed 8'hA5: 10 rounds rotating rock/paper/scissors -> player2_choice matches the golden LFSR model, always one-hot. With RPS_BOT_ADAPTIVE_EN, round k bot move beats player 1's move from round k-1.
- Rst asserted in JUDGE -> next cycle is IDLE with all outputs at reset values. start in WAIT_MOVE -> ignored, scores retained.
